valu_opa_bcast_buf: RTL and testbench
=====================================

# valu_opa_bcast_buf

Operand-A source stage for the vector ALU. Picks the operand among scalar register, 5-bit immediate, vector register group or zero. Extends each element from the current SEW to ELEN, signed or unsigned, and broadcasts scalar/immediate values across all lanes. Results go into a 2-entry valid/ready buffer between decode/operand fetch and the VALU. It is the parametrised successor of the single-width 64-bit operand-A selector.

## Interface
Parameters:
- ELEN, 64: element slot width per lane; legal values 32 or 64.
- LANES, 4: number of lanes; output width LANES*ELEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous buffer clear.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clock edge.
- valu_src  in  2  operand source: 00 scalar, 01 immediate, 10 vector register, 11 zero.
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=64.
- sext  in  1  1 = sign-extend element to ELEN, 0 = zero-extend.
- simm5  in  5  raw immediate field.
- scalar_in  in  ELEN  scalar register value.
- vreg_in  in  LANES*ELEN  vector register data; lane i at bits [i*ELEN +: ELEN].
- out_valid  out  1  dataA valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready at a clock edge.
- dataA  out  LANES*ELEN  operand A; lane i at bits [i*ELEN +: ELEN].
- out_src  out  2  valu_src tag of the entry presented on dataA.

## Operation
- Effective width W = 8 << sew, clamped to ELEN. With ELEN=32, sew=11 behaves as sew=10.
- Element for each source:
  - Scalar (00): e = scalar_in[W-1:0], the same value in every lane.
  - Immediate (01): simm5 extended straight to ELEN, sign-extended if sext else zero-extended, the same value in every lane. Because the value fits in 5 bits, SEW does not change the result.
  - Vector (10): lane i uses e = vreg_in lane i [W-1:0].
  - Zero (11): every lane is 0, regardless of sext.
- Each lane output is e extended from W to ELEN: bit W-1 is replicated if sext=1, zero-filled if sext=0. When W == ELEN the value passes through.
- The result is computed combinationally from the inputs at the accept edge and written into the buffer together with valu_src. Later input changes do not affect stored entries.
- Buffer: 2-entry FIFO with write pointer, read pointer and count (0..2).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - dataA and out_src show the head entry. When empty they show the last-popped entry, or 0 after reset.
- Push only: count+1. Pop only: count-1.
- Push and pop in the same cycle with count==1: count stays 1, the head advances and the new entry becomes head.
- No same-cycle bypass. An entry pushed at edge N is visible from edge N onward, and can be popped at edge N+1 at the earliest.
- flush=1 at an edge: count, pointers and head index go to 0. A concurrent push or pop is discarded (flush wins). Storage contents are not required to clear.
- Reset (rst_n low, asynchronous): count=0, pointers=0, storage=0. Consequently out_valid=0, in_ready=1, dataA=0, out_src=00. If reset asserts mid-transfer, buffered entries are lost. in_valid is ignored while rst_n is low.

## Timing
- Latency from accept to out_valid: 1 cycle. in_valid at edge N gives out_valid=1 after edge N.
- Sustained throughput is 1 operand/cycle when out_ready is held at 1.
- in_ready depends only on registered count, so there is no combinational path from out_ready to in_ready.
- When full, in_ready goes low after the second push. It returns high in the cycle after the first pop edge.
- dataA, out_src and out_valid come straight from registers with no input-to-output combinational path.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1 -> out_valid=0, in_ready=1, dataA=0. Release reset; after one push, out_valid=1 following the next edge.
- Scalar broadcast: ELEN=64, LANES=4, src=00, sew=00, scalar_in=0x00000000_000012F3, out_ready=1.
  - sext=1 -> all 4 lanes 0xFFFFFFFF_FFFFFFF3.
  - sext=0 -> all lanes 0x00000000_000000F3.
  - sew=11 -> all lanes 0x00000000_000012F3.
- Immediate and zero: src=01, simm5=0x1C.
  - sext=1 -> all lanes 0xFFFFFFFF_FFFFFFFC.
  - sext=0 -> all lanes 0x1C.
  - src=11 -> all lanes 0, out_src=11.
- Vector per lane: src=10, sew=01, sext=1, lanes = 0x8001, 0x7FFF, 0x1_0000, 0xFFFF_8000 -> lanes 0xFFFF_FFFF_FFFF_8001, 0x7FFF, 0x0, 0xFFFF_FFFF_FFFF_8000.
- Backpressure: out_ready=0, push A, B and offer C -> in_ready=0 after B and C is not accepted. Raise out_ready -> A, B, C delivered in order, one per cycle, with no loss or duplicate. Also hold count==1 with push and pop in the same cycle for 10 cycles -> count stays 1 and data stays in order.
- Flush: two entries buffered, assert flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and neither push nor pop took effect. Assert rst_n=0 while full -> out_valid drops immediately (asynchronously), dataA=0.

Source files
------------

// File: rtl/valu_opa_bcast_buf.sv
// -----------------------------------------------------------------------------
// valu_opa_bcast_buf
//   Operand-A source stage for the vector ALU. Selects scalar, 5-bit
//   immediate, vector register group or zero. It extends each element from
//   the current SEW to ELEN and broadcasts scalar/immediate values to every
//   lane. Results are held in a 2-entry valid/ready buffer.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of the buffer (wins over push/pop)
//   in_valid/ready : request handshake from decode/operand fetch
//   valu_src       : 00 scalar, 01 immediate, 10 vector, 11 zero
//   sew            : element width 00=8 01=16 10=32 11=64 (clamped to ELEN)
//   sext           : 1 sign-extend, 0 zero-extend
//   simm5          : raw immediate field
//   scalar_in      : scalar register value
//   vreg_in        : vector register data, lane i at [i*ELEN +: ELEN]
//   out_valid/ready: handshake towards the VALU
//   dataA          : head entry operand, lane i at [i*ELEN +: ELEN]
//   out_src        : valu_src tag of the head entry
// -----------------------------------------------------------------------------
module valu_opa_bcast_buf #(
  parameter int ELEN  = 64,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            valu_src,
  input  logic [1:0]            sew,
  input  logic                  sext,
  input  logic [4:0]            simm5,
  input  logic [ELEN-1:0]       scalar_in,
  input  logic [LANES*ELEN-1:0] vreg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*ELEN-1:0] dataA,
  output logic [1:0]            out_src
);

  localparam int DW = LANES * ELEN;

  // Extends the low W bits of e to ELEN. The mask keeps bits [W-1:0]; its top
  // set bit isolates the sign position without a variable-width bit select.
  function automatic logic [ELEN-1:0] f_extend(input logic [ELEN-1:0] e,
                                               input logic [1:0]      sew_eff,
                                               input logic            sx);
    logic [7:0]      width;
    logic [ELEN-1:0] mask;
    logic            sign;
    width = 8'd8 << sew_eff;
    mask  = ~({ELEN{1'b1}} << width);
    sign  = |(e & (mask ^ (mask >> 1)));
    return (sx && sign) ? (e | ~mask) : (e & mask);
  endfunction

  logic [1:0]      w_sew_eff;
  logic [ELEN-1:0] w_imm_ext;
  logic [DW-1:0]   w_lanes;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_nxt;
  logic            w_wptr_nxt;
  logic            w_rptr_nxt;
  logic [DW-1:0]   w_head_data_nxt;
  logic [1:0]      w_head_src_nxt;

  logic [DW-1:0]   r_mem_data [2];
  logic [1:0]      r_mem_src  [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic [DW-1:0]   r_head_data;
  logic [1:0]      r_head_src;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign dataA     = r_head_data;
  assign out_src   = r_head_src;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Effective SEW clamped to ELEN, plus the immediate extended straight to ELEN.
  always_comb begin
    w_sew_eff = sew;
    if ((ELEN == 32) && (sew == 2'b11)) begin
      w_sew_eff = 2'b10;
    end else begin
      w_sew_eff = sew;
    end
    if (sext) begin
      w_imm_ext = {{(ELEN-5){simm5[4]}}, simm5};
    end else begin
      w_imm_ext = {{(ELEN-5){1'b0}}, simm5};
    end
  end

  // Per-lane operand selection and width extension.
  always_comb begin
    w_lanes = {DW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      case (valu_src)
        2'b00:   w_lanes[i*ELEN +: ELEN] = f_extend(scalar_in, w_sew_eff, sext);
        2'b01:   w_lanes[i*ELEN +: ELEN] = w_imm_ext;
        2'b10:   w_lanes[i*ELEN +: ELEN] = f_extend(vreg_in[i*ELEN +: ELEN], w_sew_eff, sext);
        2'b11:   w_lanes[i*ELEN +: ELEN] = {ELEN{1'b0}};
        default: w_lanes[i*ELEN +: ELEN] = {ELEN{1'b0}};
      endcase
    end
  end

  // Pointer/count next state and the value the registered head output takes.
  always_comb begin
    w_count_nxt     = r_count;
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_head_data_nxt = r_head_data;
    w_head_src_nxt  = r_head_src;
    if (flush) begin
      w_count_nxt = 2'd0;
      w_wptr_nxt  = 1'b0;
      w_rptr_nxt  = 1'b0;
    end else begin
      if (w_push) begin
        w_wptr_nxt = ~r_wptr;
      end else begin
        w_wptr_nxt = r_wptr;
      end
      if (w_pop) begin
        w_rptr_nxt = ~r_rptr;
      end else begin
        w_rptr_nxt = r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
      // Empty after this edge: keep showing the last-popped entry. Otherwise
      // the new head is either the entry being written now or a stored one.
      if (w_count_nxt == 2'd0) begin
        w_head_data_nxt = r_head_data;
        w_head_src_nxt  = r_head_src;
      end else if (w_push && (r_wptr == w_rptr_nxt)) begin
        w_head_data_nxt = w_lanes;
        w_head_src_nxt  = valu_src;
      end else begin
        w_head_data_nxt = r_mem_data[w_rptr_nxt];
        w_head_src_nxt  = r_mem_src[w_rptr_nxt];
      end
    end
  end

  // Buffer storage: written at the write pointer on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_data[0] <= {DW{1'b0}};
      r_mem_data[1] <= {DW{1'b0}};
      r_mem_src[0]  <= 2'b00;
      r_mem_src[1]  <= 2'b00;
    end else if (w_push) begin
      r_mem_data[r_wptr] <= w_lanes;
      r_mem_src[r_wptr]  <= valu_src;
    end
  end

  // Pointers, occupancy and the registered head presented on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_head_data <= {DW{1'b0}};
      r_head_src  <= 2'b00;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_src  <= w_head_src_nxt;
    end
  end

endmodule

// File: tb/tb_valu_opa_bcast_buf.sv
module tb_valu_opa_bcast_buf;

  localparam int ELEN  = 64;
  localparam int LANES = 4;
  localparam int DW    = ELEN * LANES;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      valu_src;
  logic [1:0]      sew;
  logic            sext;
  logic [4:0]      simm5;
  logic [ELEN-1:0] scalar_in;
  logic [DW-1:0]   vreg_in;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   dataA;
  logic [1:0]      out_src;

  int tests_run;
  int tests_failed;

  valu_opa_bcast_buf #(.ELEN(ELEN), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .valu_src  (valu_src),
    .sew       (sew),
    .sext      (sext),
    .simm5     (simm5),
    .scalar_in (scalar_in),
    .vreg_in   (vreg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataA     (dataA),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request on the input side (in_valid raised).
  task automatic drive(input logic [1:0] src, input logic [1:0] s, input logic sx,
                       input logic [4:0] imm, input logic [63:0] sc, input logic [DW-1:0] vr);
    valu_src  = src;
    sew       = s;
    sext      = sx;
    simm5     = imm;
    scalar_in = sc;
    vreg_in   = vr;
    in_valid  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    valu_src = 2'b00; sew = 2'b11; sext = 1'b0; simm5 = 5'd0;
    scalar_in = 64'h1234; vreg_in = {DW{1'b0}};
    tick(); tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    tests_run++;
    if (dataA !== {DW{1'b0}} || out_src !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_data: dataA=%h out_src=%b expected 0/00", dataA, out_src);
    end
    rst_n = 1'b1;
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h55, {DW{1'b0}});
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || dataA !== {4{64'h55}}) begin
      tests_failed++;
      $display("FAIL reset_first_push: out_valid=%b dataA=%h expected 1/%h", out_valid, dataA, {4{64'h55}});
    end
    tick();
  endtask

  task automatic test_scalar();
    logic [1:0]  sews [3];
    logic        sxs  [3];
    logic [63:0] exps [3];
    sews = '{2'b00, 2'b00, 2'b11};
    sxs  = '{1'b1, 1'b0, 1'b1};
    exps = '{64'hFFFFFFFF_FFFFFFF3, 64'h00000000_000000F3, 64'h00000000_000012F3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, sews[i], sxs[i], 5'd0, 64'h00000000_000012F3, {DW{1'b0}});
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || dataA !== {4{exps[i]}} || out_src !== 2'b00) begin
        tests_failed++;
        $display("FAIL scalar_%0d: v=%b src=%b dataA=%h expected %h", i, out_valid, out_src, dataA, {4{exps[i]}});
      end
    end
  endtask

  task automatic test_imm_zero();
    drive(2'b01, 2'b10, 1'b1, 5'h1C, 64'hDEAD, {DW{1'b1}});
    tick();
    tests_run++;
    if (dataA !== {4{64'hFFFFFFFF_FFFFFFFC}} || out_src !== 2'b01) begin
      tests_failed++;
      $display("FAIL imm_sext: dataA=%h src=%b expected %h/01", dataA, out_src, {4{64'hFFFFFFFF_FFFFFFFC}});
    end
    drive(2'b01, 2'b00, 1'b0, 5'h1C, 64'hDEAD, {DW{1'b1}});
    tick();
    tests_run++;
    if (dataA !== {4{64'h1C}}) begin
      tests_failed++;
      $display("FAIL imm_zext: dataA=%h expected %h", dataA, {4{64'h1C}});
    end
    drive(2'b11, 2'b00, 1'b1, 5'h1C, 64'hFFFF, {DW{1'b1}});
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (dataA !== {DW{1'b0}} || out_src !== 2'b11) begin
      tests_failed++;
      $display("FAIL zero_src: dataA=%h src=%b expected 0/11", dataA, out_src);
    end
  endtask

  task automatic test_vector();
    drive(2'b10, 2'b01, 1'b1, 5'd0, 64'd0,
          {64'h00000000_FFFF8000, 64'h00000000_00010000, 64'h00000000_00007FFF, 64'h00000000_00008001});
    tick();
    tests_run++;
    if (dataA !== {64'hFFFFFFFF_FFFF8000, 64'h0, 64'h7FFF, 64'hFFFFFFFF_FFFF8001} || out_src !== 2'b10) begin
      tests_failed++;
      $display("FAIL vector_sew16: dataA=%h src=%b", dataA, out_src);
    end
    drive(2'b10, 2'b10, 1'b0, 5'd0, 64'd0,
          {64'h12345678_FFFF8000, 64'h0, 64'h0, 64'hFFFFFFFF_80000001});
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (dataA !== {64'h00000000_FFFF8000, 64'h0, 64'h0, 64'h00000000_80000001}) begin
      tests_failed++;
      $display("FAIL vector_sew32_zext: dataA=%h", dataA);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    // Backpressure: A and B fill the buffer, C is held off.
    out_ready = 1'b0;
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'hA, {DW{1'b0}});
    tick();
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'hB, {DW{1'b0}});
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || dataA !== {4{64'hA}}) begin
      tests_failed++;
      $display("FAIL full_after_b: in_ready=%b out_valid=%b dataA=%h", in_ready, out_valid, dataA);
    end
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'hC, {DW{1'b0}});
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || dataA !== {4{64'hA}}) begin
      tests_failed++;
      $display("FAIL c_blocked: in_ready=%b dataA=%h expected 0/A", in_ready, dataA);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || dataA !== {4{64'hB}}) begin
      tests_failed++;
      $display("FAIL drain_b: in_ready=%b out_valid=%b dataA=%h expected 1/1/B", in_ready, out_valid, dataA);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || dataA !== {4{64'hC}}) begin
      tests_failed++;
      $display("FAIL drain_c: out_valid=%b dataA=%h expected 1/C", out_valid, dataA);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drained: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // Steady state at one entry: push and pop every cycle.
    for (int k = 0; k < 10; k++) begin
      drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h100 + 64'(k), {DW{1'b0}});
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || dataA !== {4{64'h100 + 64'(k)}}) begin
        tests_failed++;
        $display("FAIL stream_%0d: v=%b r=%b dataA=%h expected %h", k, out_valid, in_ready, dataA, 64'h100 + 64'(k));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h11, {DW{1'b0}});
    tick();
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h22, {DW{1'b0}});
    tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h33, {DW{1'b0}});
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // Two pushes must fill exactly: the flush left count at zero.
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h44, {DW{1'b0}});
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || dataA !== {4{64'h44}}) begin
      tests_failed++;
      $display("FAIL flush_refill1: in_ready=%b dataA=%h expected 1/44", in_ready, dataA);
    end
    drive(2'b00, 2'b11, 1'b0, 5'd0, 64'h55, {DW{1'b0}});
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_refill2: in_ready=%b expected 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || dataA !== {4{64'h55}}) begin
      tests_failed++;
      $display("FAIL flush_order: out_valid=%b dataA=%h expected 1/55", out_valid, dataA);
    end
    drive(2'b01, 2'b00, 1'b1, 5'h1F, 64'd0, {DW{1'b0}});
    tick();
    in_valid = 1'b0;
    // Asynchronous reset while full.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dataA !== {DW{1'b0}} || out_src !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: v=%b r=%b src=%b dataA=%h expected 0/1/00/0", out_valid, in_ready, out_src, dataA);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_scalar();
    test_imm_zero();
    test_vector();
    test_back_to_back();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
